// File: rtl/imem_program_loader_pkg.sv
// imem_program_loader_pkg: shared state encoding and frame constants
package imem_program_loader_pkg;
  typedef logic [2:0] state_t;
  localparam state_t IDLE   = 3'd0;
  localparam state_t LEN_HI = 3'd1;
  localparam state_t LEN_LO = 3'd2;
  localparam state_t DATA   = 3'd3;
  localparam state_t WRITE  = 3'd4;
  localparam state_t CSUM   = 3'd5;
  localparam state_t DONE   = 3'd6;
  localparam state_t ERR    = 3'd7;
  localparam int FRAME_HDR_BYTES = 2;
  localparam logic [7:0] CSUM_INIT = 8'h00;
endpackage

// File: rtl/imem_program_loader_if.sv
// imem_program_loader_if: host byte link, imem write port and loader status
interface imem_program_loader_if #(parameter int ADDR_W = 8);
  logic start;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic cpu_hold;
  logic busy;
  logic done;
  logic error;
  logic [ADDR_W:0] words_loaded;
  modport master(output start, rx_data, rx_valid,
                 input rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, error, words_loaded);
  modport slave(input start, rx_data, rx_valid,
                output rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, error, words_loaded);
endinterface

// File: rtl/imem_program_loader_word_assembler.sv
// word_assembler: packs MSB-first bytes into 32-bit words, pulses on the 4th byte
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [23:0] sr;
  logic [1:0] cnt;
  assign word = {sr, byte_in};
  assign word_valid = byte_valid && cnt == 2'd3;
  // shift the first three bytes of a word in and count bytes within the word
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      sr <= '0;
      cnt <= '0;
    end else if (byte_valid) begin
      sr <= word[23:0];
      cnt <= cnt + 2'd1;
    end
  end
endmodule

// File: rtl/imem_program_loader.sv
// imem_program_loader: loads a checksummed byte-stream image into instruction memory
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input logic clk,
  input logic reset,
  imem_program_loader_if.slave bus
);
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  state_t state, state_n;
  logic [15:0] n_len;
  logic [7:0] csum;
  logic [31:0] word;
  logic word_valid, acc, restart, last;
  logic [15:0] len;
  assign acc = bus.rx_valid && bus.rx_ready;
  assign restart = bus.start && (state == IDLE || state == DONE || state == ERR);
  assign len = {n_len[15:8], bus.rx_data};
  assign last = 17'(bus.words_loaded) + 17'd1 == {1'b0, n_len};
  word_assembler u_asm (
    .clk(clk),
    .reset(reset),
    .clear(restart),
    .byte_valid(acc && state == DATA),
    .byte_in(bus.rx_data),
    .word(word),
    .word_valid(word_valid)
  );
  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else state <= state_n;
  end
  // next-state logic; start only matters outside a session
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE, ERR: state_n = bus.start ? LEN_HI : state;
      LEN_HI: state_n = acc ? LEN_LO : state;
      LEN_LO: state_n = !acc ? state : {1'b0, len} > CAP ? ERR : len == 16'd0 ? CSUM : DATA;
      DATA: state_n = word_valid ? WRITE : state;
      WRITE: state_n = last ? CSUM : DATA;
      CSUM: state_n = !acc ? state : bus.rx_data == csum ? DONE : ERR;
    endcase
  end
  // outputs decoded purely from the state register
  always_comb begin
    bus.rx_ready = state inside {LEN_HI, LEN_LO, DATA, CSUM};
    bus.imem_we = state == WRITE;
    bus.busy = state inside {LEN_HI, LEN_LO, DATA, WRITE, CSUM};
    bus.done = state == DONE;
    bus.error = state == ERR;
    bus.cpu_hold = state != DONE;
  end
  // length capture, running checksum, word counter and held write port
  always_ff @(posedge clk) begin
    if (!reset) begin
      n_len <= '0;
      csum <= CSUM_INIT;
      bus.words_loaded <= '0;
      bus.imem_addr <= '0;
      bus.imem_wdata <= '0;
    end else begin
      if (restart) begin
        csum <= CSUM_INIT;
        bus.words_loaded <= '0;
      end else begin
        if (acc && state != CSUM) csum <= csum ^ bus.rx_data;
        if (state == WRITE) bus.words_loaded <= bus.words_loaded + ONE;
      end
      if (acc && state == LEN_HI) n_len[15:8] <= bus.rx_data;
      if (acc && state == LEN_LO) n_len[7:0] <= bus.rx_data;
      if (word_valid) begin
        bus.imem_addr <= bus.words_loaded[ADDR_W-1:0];
        bus.imem_wdata <= word;
      end
    end
  end
endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader: randomized frames checked against a frame-level model
module tb_imem_program_loader;
  localparam int AW = 8;
  localparam int CAP = 1 << AW;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [AW-1:0] a;
    logic [31:0] d;
  } wr_t;
  logic clk = 0;
  logic reset = 0;
  int errors = 0;
  int checks = 0;
  wr_t exp_q[$];
  wr_t e;
  imem_program_loader_if #(.ADDR_W(AW)) bus ();
  imem_program_loader #(.ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // frame-level model: expected writes, final flags, word count and bytes consumed
  task automatic build_expect(input bq_t f, output bit d, output bit er, output int w, output int ns);
    int n;
    logic [7:0] x;
    wr_t t;
    n = int'({f[0], f[1]});
    if (n > CAP) begin
      d = 0; er = 1; w = 0; ns = 2;
    end else begin
      x = 8'h00;
      for (int i = 0; i < 2 + 4 * n; i++) x ^= f[i];
      for (int i = 0; i < n; i++) begin
        t.a = AW'(i);
        t.d = {f[2+4*i], f[3+4*i], f[4+4*i], f[5+4*i]};
        exp_q.push_back(t);
      end
      d = f[2+4*n] == x;
      er = !d;
      w = n;
      ns = 3 + 4 * n;
    end
  endtask
  function automatic bq_t make_frame(input int n, input bit good);
    bq_t f;
    logic [7:0] x;
    logic [15:0] nn;
    nn = 16'(n);
    f.push_back(nn[15:8]);
    f.push_back(nn[7:0]);
    if (n <= CAP) begin
      for (int i = 0; i < 4 * n; i++) f.push_back(8'($urandom));
      x = 8'h00;
      foreach (f[i]) x ^= f[i];
      f.push_back(good ? x : x ^ 8'(1 + $urandom_range(254, 0)));
    end
    return f;
  endfunction
  task automatic send_bytes(input bq_t f, input int ns, input int gap, input int start_at);
    int t;
    for (int k = 0; k < ns; k++) begin
      if (k == start_at) begin
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
      end
      repeat ($urandom_range(gap, 0)) @(negedge clk);
      bus.rx_data = f[k];
      bus.rx_valid = 1;
      t = 0;
      while (!bus.rx_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t == 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: byte %0d not accepted within 100 cycles", k);
        bus.rx_valid = 0;
        return;
      end
      @(negedge clk);
      bus.rx_valid = 0;
    end
  endtask
  task automatic run_frame(input string nm, input bq_t f, input int gap, input int start_at);
    bit d, er;
    int w, ns;
    build_expect(f, d, er, w, ns);
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    send_bytes(f, ns, gap, start_at);
    check({nm, "_done"}, 64'(bus.done), 64'(d));
    check({nm, "_error"}, 64'(bus.error), 64'(er));
    check({nm, "_cpu_hold"}, 64'(bus.cpu_hold), 64'(!d));
    check({nm, "_busy"}, 64'(bus.busy), 64'(0));
    check({nm, "_rx_ready"}, 64'(bus.rx_ready), 64'(0));
    check({nm, "_words"}, 64'(bus.words_loaded), 64'(w));
    check({nm, "_pending_writes"}, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask
  task automatic check_reset_vals(input string nm);
    check({nm, "_cpu_hold"}, 64'(bus.cpu_hold), 64'(1));
    check({nm, "_rx_ready"}, 64'(bus.rx_ready), 64'(0));
    check({nm, "_we"}, 64'(bus.imem_we), 64'(0));
    check({nm, "_addr"}, 64'(bus.imem_addr), 64'(0));
    check({nm, "_wdata"}, 64'(bus.imem_wdata), 64'(0));
    check({nm, "_busy"}, 64'(bus.busy), 64'(0));
    check({nm, "_done"}, 64'(bus.done), 64'(0));
    check({nm, "_error"}, 64'(bus.error), 64'(0));
    check({nm, "_words"}, 64'(bus.words_loaded), 64'(0));
  endtask
  // every write is matched in order against the model; hold tracks done each cycle
  always @(negedge clk) begin
    if (reset) begin
      if (bus.imem_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0h data %0h with none expected", bus.imem_addr, bus.imem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(bus.imem_addr), 64'(e.a));
          check("wr_data", 64'(bus.imem_wdata), 64'(e.d));
        end
      end
      check("hold_vs_done", 64'(bus.cpu_hold), 64'(!bus.done));
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    bq_t f1, f2, f3, f4, fr;
    bit d, er;
    int w, ns;
    bus.start = 0;
    bus.rx_valid = 0;
    bus.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1;
    @(negedge clk);
    f1 = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h57};
    f2 = f1;
    f2[10] = 8'h58;
    f3 = '{8'h00, 8'h00, 8'h00};
    f4 = '{8'h01, 8'h2C};
    build_expect(f1, d, er, w, ns);
    check("model_w0", 64'(exp_q[0].d), 64'h20080005);
    check("model_w1", 64'(exp_q[1].d), 64'h01095020);
    check("model_good_csum", 64'(d), 64'(1));
    exp_q.delete();
    build_expect(f2, d, er, w, ns);
    check("model_bad_csum", 64'(d), 64'(0));
    exp_q.delete();
    build_expect(f4, d, er, w, ns);
    check("model_overflow_bytes", 64'(ns), 64'(2));
    run_frame("nominal", f1, 0, -1);
    run_frame("bad_csum", f2, 0, -1);
    run_frame("empty", f3, 0, -1);
    run_frame("overflow", f4, 0, -1);
    run_frame("stall_start", f1, 7, 5);
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    send_bytes(f1, 4, 2, -1);
    check("pre_reset_busy", 64'(bus.busy), 64'(1));
    reset = 0;
    @(negedge clk);
    check_reset_vals("mid_reset");
    reset = 1;
    @(negedge clk);
    run_frame("after_reset", f1, 1, -1);
    run_frame("full_cap", make_frame(CAP, 1), 0, -1);
    run_frame("over_by_one", make_frame(CAP + 1, 1), 0, -1);
    for (int i = 0; i < 12; i++) begin
      fr = make_frame(($urandom_range(9, 0) == 0) ? $urandom_range(65535, CAP + 1) : $urandom_range(6, 0),
                      $urandom_range(3, 0) != 0);
      run_frame($sformatf("rand%0d", i), fr, $urandom_range(3, 0), -1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writer-side counterpart to the processor's instruction fetch path: receives a program image as a byte stream from a host and writes it word-by-word into instruction memory.
- Holds the processor in reset until a complete image has been loaded and checksum-verified.
- Sits between the host byte link (UART RX or testbench) and the instruction memory write port, beside the processor top.

Parameters:
- ADDR_W, 8, instruction memory word-address width; capacity is 2**ADDR_W words.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load session
- rx_data  in  8  host byte
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  instruction word
- cpu_hold  out  1  high holds the processor in reset
- busy  out  1  load session in progress
- done  out  1  sticky, image loaded and checksum OK
- error  out  1  sticky, length overflow or checksum mismatch
- words_loaded  out  ADDR_W+1  count of words written this session

Behaviour:
- Reset (reset==0 at a clk edge) forces state IDLE and these output values: cpu_hold=1, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0, words_loaded=0. Reset overrides everything, including mid-session.
- Byte transfer occurs on rx_valid & rx_ready. rx_ready is registered and is 1 only in LEN_HI, LEN_LO, DATA and CSUM.
- Frame format: N[15:8], N[7:0], then 4*N payload bytes (each word MSB first), then one checksum byte. The checksum is the XOR of all preceding frame bytes, length bytes included.
- IDLE:
  - start goes to LEN_HI.
  - On that transition: clear done, error, words_loaded, the running checksum and the word index; set cpu_hold=1.
- DONE and ERR: start behaves exactly as in IDLE and restarts a session.
- LEN_HI / LEN_LO: capture N.
  - After LEN_LO: N > 2**ADDR_W goes to ERR.
  - N==0 goes to CSUM.
  - Otherwise go to DATA.
- DATA:
  - Shift accepted bytes into a 32-bit assembler.
  - After the 4th byte, go to WRITE.
- WRITE (exactly one cycle, rx_ready=0):
  - Drive imem_we=1, imem_addr=index, imem_wdata=assembled word.
  - Then increment index and words_loaded.
  - If index was N-1, go to CSUM; otherwise go to DATA.
- CSUM: on the accepted byte, go to DONE if it equals the running checksum, otherwise go to ERR.
- DONE: done=1, cpu_hold=0, busy=0.
- ERR: error=1, cpu_hold=1, busy=0. Words already written are not rolled back.
- busy=1 in LEN_HI through CSUM. start is ignored while busy.
- Latency and throughput:
  - The write strobe occurs the cycle after the 4th byte of a word is accepted.
  - Peak throughput is 4 bytes per 5 cycles.
  - rx_valid gaps of any length stall the session without error; there is no timeout.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- N == 2**ADDR_W is legal: the final word is written to address 2**ADDR_W-1, and words_loaded saturates at that exact value.

Decomposition:
- Shared package: state encoding localparams (IDLE, LEN_HI, LEN_LO, DATA, WRITE, CSUM, DONE, ERR), FRAME_HDR_BYTES=2, CSUM_INIT=8'h00.
- One sub-module: word_assembler.
  - Contents: 8-to-32 shift register, 2-bit byte counter, word_valid pulse.
  - Controls: clear input from the FSM, same clock and reset.

Test Plan:
1. Nominal load:
   - Stimulus: start, then bytes 00 02 20 08 00 05 01 09 50 20 57.
   - Response: writes addr0=0x20080005 and addr1=0x01095020; done=1, error=0, cpu_hold=0, words_loaded=2.
2. Bad checksum:
   - Stimulus: same frame with checksum 0x58.
   - Response: both writes still occur; error=1, done=0, cpu_hold=1.
3. Empty image:
   - Stimulus: 00 00 00.
   - Response: no imem_we; done=1, words_loaded=0.
4. Length overflow (ADDR_W=8):
   - Stimulus: 01 2C (N=300).
   - Response: ERR the cycle after LEN_LO; rx_ready=0; no writes; error=1.
5. Stalls and ignored start:
   - Stimulus: test 1 frame with random 0-7 cycle rx_valid gaps, plus a start pulse mid-DATA.
   - Response: identical writes and final state to test 1; the start pulse has no effect.
6. Reset mid-session:
   - Stimulus: reset=0 for one cycle during DATA after 2 payload bytes.
   - Response: all outputs at reset values next cycle; a subsequent start with the test 1 frame completes with done=1.
